spi_encoder_link: RTL and testbench

//  SPI slave command/readback endpoint plus quadrature encoder counter, all in one clk domain.
//  SPI pins are oversampled and edge-detected in clk; 32-bit frames carry motor-PWM writes or readback-address selects.

---
 rtl/spi_encoder_link_if.sv | 33 +++
 rtl/spi_encoder_link.sv | 172 +++++++++++++++++
 tb/tb_spi_encoder_link.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_encoder_link_if.sv
// Pin-level bundle between the host SPI bus / encoder pins and the link endpoint.
// slave = the endpoint, master = whatever drives the pins and consumes the PWM/encoder outputs.
interface spi_encoder_link_if #(
   parameter int CNT_W = 16,
   parameter int PWM_W = 11
);
   logic             spi_clk;
   logic             cs;
   logic             spi_incoming;
   logic             spi_outgoing;
   logic             enc_a;
   logic             enc_b;
   logic             enc_z;
   logic             wr_valid;
   logic [7:0]       motor_addr;
   logic [PWM_W-1:0] pwm_period;
   logic [PWM_W-1:0] period;
   logic [CNT_W-1:0] enc_count;
   logic             enc_dir;
   logic             frame_valid;

   modport slave (
      input  spi_clk, cs, spi_incoming, enc_a, enc_b, enc_z,
      output spi_outgoing, wr_valid, motor_addr, pwm_period, period,
             enc_count, enc_dir, frame_valid
   );

   modport master (
      output spi_clk, cs, spi_incoming, enc_a, enc_b, enc_z,
      input  spi_outgoing, wr_valid, motor_addr, pwm_period, period,
             enc_count, enc_dir, frame_valid
   );
endinterface

// File: rtl/spi_encoder_link.sv
// SPI mode-0 slave (oversampled in clk) with motor-PWM write/readback decode and a 4x quadrature counter.
// Optional: define ENC_INDEX_RESET_EN so a synced enc_z rising edge clears the position count.
module spi_encoder_link #(
   parameter int DATA_W      = 32,
   parameter int CNT_W       = 16,
   parameter int PWM_W       = 11,
   parameter int PERIOD_RST  = 1001,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   spi_encoder_link_if.slave bus
);

   localparam int BC_W = $clog2(DATA_W + 1);
   localparam logic [BC_W-1:0] BC_FULL = BC_W'(DATA_W);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);
   // Input bit order: 0 sclk, 1 cs, 2 enc_a, 3 enc_b, 4 enc_z, 5 mosi. cs idles high out of reset.
   localparam logic [5:0] SYNC_RST = 6'b00_0010;

   logic [SYNC_STAGES-1:0][5:0] sync_q;
   logic [4:0]                  prev_q;
   logic [5:0]                  cur;

   logic [DATA_W-1:0] tx_shift_q;
   logic [DATA_W-2:0] rx_shift_q;
   logic [DATA_W-1:0] rx_word_q;
   logic [BC_W-1:0]   bit_cnt_q;
   logic              frame_valid_q;

   logic             wr_valid_q;
   logic [7:0]       motor_addr_q;
   logic [PWM_W-1:0] pwm_period_q;
   logic [PWM_W-1:0] period_q;
   logic [7:0]       read_addr_q;

   logic [CNT_W-1:0] enc_count_q, enc_count_d;
   logic             enc_dir_q, enc_dir_d;

   logic [DATA_W-1:0] readback;
   logic sclk_rise, sclk_fall, cs_fall, cs_cur, mosi_cur;
   logic [1:0] pos_cur, pos_prev, step;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= {SYNC_STAGES{SYNC_RST}};
         prev_q <= SYNC_RST[4:0];
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0],
                    {bus.spi_incoming, bus.enc_z, bus.enc_b, bus.enc_a, bus.cs, bus.spi_clk}};
         prev_q <= cur[4:0];
      end
   end

   assign cur       = sync_q[SYNC_STAGES-1];
   assign sclk_rise = cur[0] & ~prev_q[0];
   assign sclk_fall = ~cur[0] & prev_q[0];
   assign cs_cur    = cur[1];
   assign cs_fall   = ~cur[1] & prev_q[1];
   assign mosi_cur  = cur[5];

   always_comb begin
      readback = '0;
      case (read_addr_q)
         8'd0:    readback[PWM_W-1:0] = period_q;
         8'd1:    readback[CNT_W:0]   = {enc_dir_q, enc_count_q};
         default: readback            = rx_word_q;
      endcase
   end

   // Bits arriving after a full word but before cs rises are dropped by holding bit_cnt at DATA_W.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_shift_q    <= '0;
         rx_shift_q    <= '0;
         rx_word_q     <= '0;
         bit_cnt_q     <= '0;
         frame_valid_q <= 1'b0;
      end else begin
         frame_valid_q <= 1'b0;
         if (cs_fall) begin
            tx_shift_q <= readback;
            bit_cnt_q  <= '0;
         end else if (cs_cur) begin
            bit_cnt_q <= '0;
         end else begin
            if (sclk_rise && bit_cnt_q != BC_FULL) begin
               rx_shift_q <= {rx_shift_q[DATA_W-3:0], mosi_cur};
               bit_cnt_q  <= bit_cnt_q + BC_W'(1);
               if (bit_cnt_q == BC_LAST) begin
                  rx_word_q     <= {rx_shift_q, mosi_cur};
                  frame_valid_q <= 1'b1;
               end
            end
            if (sclk_fall) tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_valid_q   <= 1'b0;
         motor_addr_q <= '0;
         pwm_period_q <= '0;
         period_q     <= PWM_W'(PERIOD_RST);
         read_addr_q  <= '0;
      end else begin
         wr_valid_q <= 1'b0;
         if (frame_valid_q) begin
            case (rx_word_q[31:24])
               8'h00: begin
                  wr_valid_q   <= 1'b1;
                  motor_addr_q <= rx_word_q[PWM_W+7:PWM_W];
                  pwm_period_q <= rx_word_q[PWM_W-1:0];
                  period_q     <= rx_word_q[PWM_W-1:0];
               end
               8'h01:   read_addr_q <= rx_word_q[7:0];
               default: ;
            endcase
         end
      end
   end

   // Gray position 00,01,11,10 -> 0..3; a mod-4 difference of 2 means both bits moved together.
   assign pos_cur  = {cur[2], cur[2] ^ cur[3]};
   assign pos_prev = {prev_q[2], prev_q[2] ^ prev_q[3]};
   assign step     = pos_cur - pos_prev;

   always_comb begin
      enc_count_d = enc_count_q;
      enc_dir_d   = enc_dir_q;
      case (step)
         2'd1: begin
            enc_count_d = enc_count_q + CNT_W'(1);
            enc_dir_d   = 1'b1;
         end
         2'd3: begin
            enc_count_d = enc_count_q - CNT_W'(1);
            enc_dir_d   = 1'b0;
         end
         default: ;
      endcase
`ifdef ENC_INDEX_RESET_EN
      if (cur[4] & ~prev_q[4]) enc_count_d = '0;
`endif
   end

`ifndef ENC_INDEX_RESET_EN
   logic enc_z_unused;
   assign enc_z_unused = cur[4] ^ prev_q[4];
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         enc_count_q <= '0;
         enc_dir_q   <= 1'b0;
      end else begin
         enc_count_q <= enc_count_d;
         enc_dir_q   <= enc_dir_d;
      end
   end

   assign bus.spi_outgoing = ~cs_cur & tx_shift_q[DATA_W-1];
   assign bus.wr_valid     = wr_valid_q;
   assign bus.motor_addr   = motor_addr_q;
   assign bus.pwm_period   = pwm_period_q;
   assign bus.period       = period_q;
   assign bus.enc_count    = enc_count_q;
   assign bus.enc_dir      = enc_dir_q;
   assign bus.frame_valid  = frame_valid_q;

endmodule

// File: tb/tb_spi_encoder_link.sv
// Directed bench for spi_encoder_link: a register-level model of period/readback/encoder position,
// compared every idle cycle, plus literal expectations for the headline scenarios.
module tb_spi_encoder_link;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_encoder_link_if #(.CNT_W(16), .PWM_W(11)) bus();

   spi_encoder_link dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_err    = 0;

   logic [10:0] m_period;
   logic [15:0] m_count;
   logic        m_dir;
   logic [7:0]  m_raddr;
   logic [31:0] m_last;
   bit          settled = 1'b0;

   logic [7:0]  exp_motor;
   logic [10:0] exp_pwm;
   logic [7:0]  last_motor;
   logic [10:0] last_pwm;
   int          wr_seen = 0;
   int          fv_seen = 0;
   logic [31:0] miso;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_readback();
      case (m_raddr)
         8'd0:    return {21'b0, m_period};
         8'd1:    return {15'b0, m_dir, m_count};
         default: return m_last;
      endcase
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.wr_valid) begin
            wr_seen++;
            last_motor = bus.motor_addr;
            last_pwm   = bus.pwm_period;
            chk("wr_motor_addr", {24'b0, bus.motor_addr}, {24'b0, exp_motor});
            chk("wr_pwm_period", {21'b0, bus.pwm_period}, {21'b0, exp_pwm});
            chk("wr_period_reg", {21'b0, bus.period}, {21'b0, exp_pwm});
         end
         if (bus.frame_valid) fv_seen++;
         if (settled) begin
            chk("idle_period", {21'b0, bus.period}, {21'b0, m_period});
            chk("idle_enc_count", {16'b0, bus.enc_count}, {16'b0, m_count});
            chk("idle_enc_dir", {31'b0, bus.enc_dir}, {31'b0, m_dir});
            chk("idle_miso", {31'b0, bus.spi_outgoing}, 32'd0);
            chk("idle_pulses", {30'b0, bus.wr_valid, bus.frame_valid}, 32'd0);
         end
      end
   end

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      settled          = 1'b0;
      bus.cs           = 1'b1;
      bus.spi_clk      = 1'b0;
      bus.spi_incoming = 1'b0;
      bus.enc_a        = 1'b0;
      bus.enc_b        = 1'b0;
      bus.enc_z        = 1'b0;
      rst = 1'b1;
      clks(4);
      m_period = 11'd1001;
      m_count  = '0;
      m_dir    = 1'b0;
      m_raddr  = '0;
      m_last   = '0;
      rst = 1'b0;
      clks(6);
      settled = 1'b1;
   endtask

   task automatic send_frame(input logic [31:0] w, input int nbits, output logic [31:0] rx);
      logic [31:0] exp_rb;
      int wr0, fv0;
      bit complete;
      exp_rb    = m_readback();
      wr0       = wr_seen;
      fv0       = fv_seen;
      complete  = (nbits >= 32);
      settled   = 1'b0;
      exp_motor = w[18:11];
      exp_pwm   = w[10:0];
      rx        = '0;
      bus.cs = 1'b0;
      clks(8);
      for (int i = 0; i < nbits; i++) begin
         bus.spi_incoming = w[31-i];
         clks(8);
         rx = {rx[30:0], bus.spi_outgoing};
         bus.spi_clk = 1'b1;
         clks(8);
         bus.spi_clk = 1'b0;
      end
      clks(8);
      bus.cs = 1'b1;
      clks(12);
      chk("frame_valid_pulses", 32'(fv_seen - fv0), complete ? 32'd1 : 32'd0);
      chk("wr_valid_pulses", 32'(wr_seen - wr0), (complete && w[31:24] == 8'h00) ? 32'd1 : 32'd0);
      if (complete) begin
         chk("miso_readback", rx, exp_rb);
         if (w[31:24] == 8'h00) m_period = w[10:0];
         if (w[31:24] == 8'h01) m_raddr  = w[7:0];
         m_last = w;
      end
      settled = 1'b1;
   endtask

   // mv: +1 forward step, -1 reverse step, 2 = both pins toggle together (invalid)
   task automatic enc_move(input int mv);
      logic [1:0] p, np;
      settled = 1'b0;
      p = {bus.enc_a, bus.enc_a ^ bus.enc_b};
      if (mv == 2) begin
         bus.enc_a = ~bus.enc_a;
         bus.enc_b = ~bus.enc_b;
      end else begin
         np = p + 2'(mv);
         bus.enc_a = np[1];
         bus.enc_b = np[1] ^ np[0];
         m_count = m_count + 16'(mv);
         m_dir   = (mv > 0);
      end
      clks(6);
      settled = 1'b1;
   endtask

   task automatic pulse_z();
      settled = 1'b0;
      bus.enc_z = 1'b1;
      clks(6);
`ifdef ENC_INDEX_RESET_EN
      m_count = '0;
`endif
      bus.enc_z = 1'b0;
      clks(6);
      settled = 1'b1;
   endtask

   initial begin
      do_reset();
      chk("rst_period", {21'b0, bus.period}, 32'd1001);
      chk("rst_enc_count", {16'b0, bus.enc_count}, 32'd0);
      chk("rst_enc_dir", {31'b0, bus.enc_dir}, 32'd0);
      chk("rst_miso", {31'b0, bus.spi_outgoing}, 32'd0);
      clks(10);
      chk("rst_no_frames", 32'(fv_seen), 32'd0);
      chk("rst_no_writes", 32'(wr_seen), 32'd0);

      send_frame(32'h0000_2BE8, 32, miso);
      chk("t2_miso_period_rst", miso, 32'h0000_03E9);
      chk("t2_motor_addr", {24'b0, last_motor}, 32'd5);
      chk("t2_pwm_period", {21'b0, last_pwm}, 32'd1000);
      chk("t2_period", {21'b0, bus.period}, 32'd1000);

      send_frame(32'h0100_0001, 32, miso);
      for (int i = 0; i < 20; i++) enc_move(1);
      send_frame(32'h0100_0002, 32, miso);
      chk("t3_readback_enc", miso, 32'h0001_0014);
      send_frame(32'h1234_5678, 32, miso);
      chk("t3_echo_select", miso, 32'h0100_0002);
      send_frame(32'h0100_0000, 32, miso);
      chk("t3_echo_ignored_cmd", miso, 32'h1234_5678);
      send_frame(32'h0100_0003, 32, miso);
      chk("t3_readback_period", miso, 32'h0000_03E8);

      do_reset();
      enc_move(-1);
      chk("t4_rev_wrap_count", {16'b0, bus.enc_count}, 32'h0000_FFFF);
      chk("t4_rev_dir", {31'b0, bus.enc_dir}, 32'd0);
      enc_move(2);
      chk("t4_invalid_count", {16'b0, bus.enc_count}, 32'h0000_FFFF);
      chk("t4_invalid_dir", {31'b0, bus.enc_dir}, 32'd0);
      enc_move(1);
      chk("t4_fwd_wrap_count", {16'b0, bus.enc_count}, 32'd0);
      chk("t4_fwd_dir", {31'b0, bus.enc_dir}, 32'd1);

      send_frame(32'h0000_2BE8, 17, miso);
      chk("t5_period_kept", {21'b0, bus.period}, 32'd1001);
      send_frame(32'h0000_1801, 32, miso);
      chk("t5_motor_addr", {24'b0, last_motor}, 32'd3);
      chk("t5_period", {21'b0, bus.period}, 32'd1);

      for (int i = 0; i < 32'h123; i++) enc_move(1);
      chk("t6_count_before_z", {16'b0, bus.enc_count}, 32'h0000_0123);
      pulse_z();
`ifdef ENC_INDEX_RESET_EN
      chk("t6_index_clear", {16'b0, bus.enc_count}, 32'd0);
`else
      chk("t6_index_ignored", {16'b0, bus.enc_count}, 32'h0000_0123);
`endif
      chk("t6_dir_after_z", {31'b0, bus.enc_dir}, 32'd1);

      settled = 1'b0;
      clks(2);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
